// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// While busy, further requests are ignored; results land on the edge where busy falls.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  // state | meaning
  // IDLE  | accepting requests; MTHI/MTLO write immediately
  // RUN   | mult/div in flight, counting down to commit
  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic [2:0]  op_q, op_nx;
  logic [31:0] a_q, a_nx, b_q, b_nx;
  logic [31:0] hi_nx, lo_nx;

  logic [63:0] a_ext, b_ext, prod;
  logic        div_signed, neg_quo, neg_rem;
  logic [31:0] mag_a, mag_b, div_b, uquo, urem, quo, rem;

  // One 64-bit multiplier serves both flavours; the low 64 bits of the
  // extended product are the exact 32x32 result either way.
  always_comb begin
    a_ext = (op_q == OP_MULTU) ? {32'b0, a_q} : {{32{a_q[31]}}, a_q};
    b_ext = (op_q == OP_MULTU) ? {32'b0, b_q} : {{32{b_q[31]}}, b_q};
    prod  = a_ext * b_ext;
  end

  // Signed divide on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  always_comb begin
    div_signed = (op_q != OP_DIVU);
    neg_quo    = div_signed & (a_q[31] ^ b_q[31]);
    neg_rem    = div_signed & a_q[31];
    mag_a      = (div_signed && a_q[31]) ? (~a_q + 32'd1) : a_q;
    mag_b      = (div_signed && b_q[31]) ? (~b_q + 32'd1) : b_q;
    div_b      = (mag_b == 32'd0) ? 32'd1 : mag_b;
    uquo       = mag_a / div_b;
    urem       = mag_a % div_b;
    quo        = neg_quo ? (~uquo + 32'd1) : uquo;
    rem        = neg_rem ? (~urem + 32'd1) : urem;
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    op_nx    = op_q;
    a_nx     = a_q;
    b_nx     = b_q;
    hi_nx    = HI;
    lo_nx    = LO;
    case (state)
      IDLE: begin
        if (start) begin
          if (op <= OP_DIVU) begin
            op_nx    = op;
            a_nx     = A;
            b_nx     = B;
            cnt_nx   = op[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
            state_nx = RUN;
          end else if (op == OP_MTHI) begin
            hi_nx = A;
          end else if (op == OP_MTLO) begin
            lo_nx = A;
          end
        end
      end
      RUN: begin
        cnt_nx = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nx = IDLE;
          if (!op_q[1]) begin
            hi_nx = prod[63:32];
            lo_nx = prod[31:0];
          end else if (b_q != 32'd0) begin
            hi_nx = rem;
            lo_nx = quo;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      HI    <= '0;
      LO    <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      op_q  <= op_nx;
      a_q   <= a_nx;
      b_q   <= b_nx;
      HI    <= hi_nx;
      LO    <= lo_nx;
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: directed vectors then random ops against an arithmetic model
// built from 64-bit integer math.
module tb_md_unit;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        busy;
  logic [31:0] HI, LO;

  int checks = 0;
  int errors = 0;
  logic [31:0] ref_hi = 32'd0;
  logic [31:0] ref_lo = 32'd0;

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint x, y, q, r;
    case (o)
      3'd0: begin
        x = longint'($signed(a));
        y = longint'($signed(b));
        p = x * y;
        ref_hi = p[63:32];
        ref_lo = p[31:0];
      end
      3'd1: begin
        p = {32'b0, a} * {32'b0, b};
        ref_hi = p[63:32];
        ref_lo = p[31:0];
      end
      3'd2: if (b != 32'd0) begin
        x = longint'($signed(a));
        y = longint'($signed(b));
        q = x / y;
        r = x % y;
        ref_lo = q[31:0];
        ref_hi = r[31:0];
      end
      3'd3: if (b != 32'd0) begin
        ref_lo = a / b;
        ref_hi = a % b;
      end
      3'd4: ref_hi = a;
      3'd5: ref_lo = a;
      default: ;
    endcase
  endtask

  // Called and returns on a falling edge; returns in the first cycle busy is low.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input bit interfere);
    int n, want;
    want = (o <= 3'd1) ? MC : (o <= 3'd3) ? DC : 0;
    model(o, a, b);
    start = 1'b1; op = o; A = a; B = b;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      start = interfere && (n == 2 || n == 3);
      op    = (n == 2) ? 3'd4 : 3'd2;
      A     = (n == 2) ? 32'hDEAD : $urandom;
      B     = $urandom;
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, " busy_len"}, 32'(n), 32'(want));
    check({tag, " hi"}, HI, ref_hi);
    check({tag, " lo"}, LO, ref_lo);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    #1;
    check("rst busy", {31'b0, busy}, 32'd0);
    check("rst hi", HI, 32'd0);
    check("rst lo", LO, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // abort a MULT part-way through
    start = 1'b1; op = 3'd0; A = 32'd3; B = 32'd4;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("abort busy before", {31'b0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    check("abort busy", {31'b0, busy}, 32'd0);
    check("abort hi", HI, 32'd0);
    check("abort lo", LO, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    check("abort later busy", {31'b0, busy}, 32'd0);
    check("abort later hi", HI, 32'd0);
    check("abort later lo", LO, 32'd0);

    run_op("mult", 3'd0, 32'hFFFFFFFE, 32'd3, 1'b0);
    check("mult const hi", HI, 32'hFFFFFFFF);
    check("mult const lo", LO, 32'hFFFFFFFA);
    run_op("multu", 3'd1, 32'hFFFFFFFE, 32'd3, 1'b0);
    check("multu const hi", HI, 32'h00000002);
    check("multu const lo", LO, 32'hFFFFFFFA);
    run_op("div", 3'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
    check("div const lo", LO, 32'hFFFFFFFD);
    check("div const hi", HI, 32'hFFFFFFFF);
    run_op("divu", 3'd3, 32'd7, 32'd2, 1'b0);
    check("divu const lo", LO, 32'd3);
    check("divu const hi", HI, 32'd1);

    run_op("mthi", 3'd4, 32'h11, 32'd0, 1'b0);
    run_op("mtlo", 3'd5, 32'h22, 32'd0, 1'b0);
    run_op("div0", 3'd2, 32'd5, 32'd0, 1'b0);
    check("div0 const hi", HI, 32'h11);
    check("div0 const lo", LO, 32'h22);
    run_op("ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    check("ovf const lo", LO, 32'h80000000);
    check("ovf const hi", HI, 32'd0);

    run_op("interlock", 3'd0, 32'd7, 32'd9, 1'b1);
    check("interlock const lo", LO, 32'd63);
    run_op("b2b mthi", 3'd4, 32'hBEEF, 32'd0, 1'b0);
    check("b2b const hi", HI, 32'hBEEF);
    run_op("nop6", 3'd6, 32'h1234, 32'h5678, 1'b0);
    run_op("nop7", 3'd7, 32'h4321, 32'h8765, 1'b0);

    repeat (40) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 5) == 0) rb = 32'd0;
      if ($urandom_range(0, 7) == 0) rb = 32'($urandom_range(1, 9));
      if ($urandom_range(0, 9) == 0) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
      run_op("rand", ro, ra, rb, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers.
- Sits directly downstream of the register file, parallel to the ALU. Consumes the RF read data (rs value on A, rt value on B).
- Serves mult/multu/div/divu/mthi/mtlo. Its busy output lets the control path stall issue while an operation is in flight.

Parameters:
MULT_CYCLES, 5, number of cycles busy stays high for MULT/MULTU (legal range 1..15)
DIV_CYCLES, 10, number of cycles busy stays high for DIV/DIVU (legal range 1..15)

Ports:
clk    input   1   system clock, all state updates on rising edge
reset  input   1   asynchronous, active-low reset (one clock; reset is asynchronous and active-low)
start  input   1   operation request, sampled on rising clk edge
op     input   3   0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO 6,7=no-op
A      input   32  operand from RF read port 1 (rs)
B      input   32  operand from RF read port 2 (rt)
busy   output  1   high while a mult/div is in flight
HI     output  32  HI register (registered output)
LO     output  32  LO register (registered output)

Behaviour:
- Reset (reset=0, asynchronous):
  - HI=0, LO=0, busy=0; internal counter and operand latches cleared; FSM forced to IDLE.
  - An in-flight operation is aborted with no result written.
  - Deassertion takes effect for the next rising edge.
- FSM states: IDLE, RUN.
- IDLE:
  - start=1 with op in 0..3: latch A, B and op; load counter with MULT_CYCLES (op 0,1) or DIV_CYCLES (op 2,3); go to RUN. busy=1 from the cycle after the start edge.
  - start=1 with op=4: HI<=A at that edge. op=5: LO<=A at that edge. busy stays 0; stay in IDLE.
  - start=1 with op 6/7, or start=0: no state change.
- RUN:
  - Counter decrements each edge.
  - On the edge where the counter reaches 0: write the result to HI/LO, set busy=0, return to IDLE.
  - Net effect: busy is high for exactly N cycles. New HI/LO values become visible in the same cycle busy falls.
  - Any start in RUN (any op, including MTHI/MTLO) is ignored. The request is not queued.
  - A/B changes during RUN have no effect; the latched operands are used.
  - HI/LO hold their old values during RUN.
- Arithmetic:
  - MULT: {HI,LO} = signed 32x32 -> 64-bit product.
  - MULTU: {HI,LO} = unsigned 32x32 -> 64-bit product.
  - DIV: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend (A).
  - DIVU: LO = unsigned quotient; HI = unsigned remainder.
  - Signed overflow, 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divide by zero (B=0, DIV or DIVU): busy still runs the full DIV_CYCLES; HI and LO are left unchanged at completion.
- Back-to-back: a new start is accepted in the first cycle busy=0, i.e. the cycle after the completion edge.
- Results may be computed combinationally from the latched operands and committed at completion. Only the cycle-level timing above is architectural.

Test Plan:
- Reset mid-op: start MULT A=3 B=4 with HI=LO=0, pull reset low after 2 busy cycles -> busy=0, HI=0, LO=0 immediately. After release, no result is ever written.
- MULT signed: A=0xFFFFFFFE (-2), B=3 -> busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV signed: A=0xFFFFFFF9 (-7), B=2 -> busy high exactly 10 cycles, then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU A=7 B=2 -> LO=3, HI=1.
- Divide by zero and overflow:
  - Preload HI=0x11, LO=0x22 via MTHI/MTLO, then DIV A=5 B=0 -> busy 10 cycles, HI=0x11, LO=0x22 unchanged.
  - DIV A=0x80000000 B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- Busy interlock:
  - During a MULT, issue start with MTHI A=0xDEAD, and separately start with DIV -> both ignored; MULT result is correct.
  - Changing A/B mid-run does not alter the result.
  - MTHI A=0xBEEF issued the cycle after busy falls -> HI=0xBEEF next edge, busy stays 0.
